// File: rtl/count_wrap_pkg.sv
// Shared types and defaults for the counter wrap extender and its step classifier.
package count_wrap_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int EXT_W_DEF = 8;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  typedef enum logic [2:0] {
    CL_HOLD,
    CL_STEP,
    CL_WRAP_UP,
    CL_WRAP_DN,
    CL_JUMP
  } step_cls_e;
endpackage

// File: rtl/count_step_classify.sv
// Classifies the move between two consecutive counter samples.
module count_step_classify
  import count_wrap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] q_r,
  input  logic [CNT_W-1:0] q_in,
  output step_cls_e        cls
);
  localparam logic [CNT_W-1:0] Q_MAX = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Wrap cases are tested before the +/-1 check, which would otherwise match them modulo 2^CNT_W.
  always_comb begin
    if (q_in == q_r)                        cls = CL_HOLD;
    else if (q_r == Q_MAX && q_in == '0)    cls = CL_WRAP_UP;
    else if (q_r == '0 && q_in == Q_MAX)    cls = CL_WRAP_DN;
    else if (q_in == q_r + ONE || q_in == q_r - ONE) cls = CL_STEP;
    else                                    cls = CL_JUMP;
  end
endmodule

// File: rtl/count_wrap_extender.sv
// Extends a 4-bit up/down counter into a wider signed running count by tracking wraps;
// loads force a resync, and status pulses/sticky flags are registered.
module count_wrap_extender
  import count_wrap_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EXT_W = EXT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       q_in,
  input  logic                   load_in,
  input  logic [EXT_W+CNT_W-1:0] cmp_val,
  output logic [EXT_W+CNT_W-1:0] full_count,
  output logic                   valid,
  output logic                   wrap_up,
  output logic                   wrap_dn,
  output logic                   hit,
  output logic                   ext_ovf,
  output logic                   jump_err
);
  localparam logic [EXT_W-1:0] EXT_MAX = {1'b0, {(EXT_W-1){1'b1}}};
  localparam logic [EXT_W-1:0] EXT_MIN = {1'b1, {(EXT_W-1){1'b0}}};
  localparam logic [EXT_W-1:0] EXT_ONE = EXT_W'(1);

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] q_r, q_r_d;
  logic [EXT_W-1:0] ext, ext_d;
  logic             valid_d, wrap_up_d, wrap_dn_d, hit_d, ext_ovf_d, jump_err_d;
  step_cls_e        cls;

  count_step_classify #(.CNT_W(CNT_W)) u_cls (
    .q_r  (q_r),
    .q_in (q_in),
    .cls  (cls)
  );

  assign full_count = {ext, q_r};

  always_comb begin
    state_d    = state;
    q_r_d      = q_in;
    ext_d      = ext;
    valid_d    = valid;
    wrap_up_d  = 1'b0;
    wrap_dn_d  = 1'b0;
    ext_ovf_d  = ext_ovf;
    jump_err_d = jump_err;
    if (load_in) begin
      // Counter may change at this same edge; whatever it did is not a real step.
      state_d = ST_RESYNC;
      ext_d   = '0;
      valid_d = 1'b0;
    end else if (state == ST_TRACK) begin
      case (cls)
        CL_WRAP_UP: begin
          ext_d     = ext + EXT_ONE;
          wrap_up_d = 1'b1;
          if (ext == EXT_MAX) ext_ovf_d = 1'b1;
        end
        CL_WRAP_DN: begin
          ext_d     = ext - EXT_ONE;
          wrap_dn_d = 1'b1;
          if (ext == EXT_MIN) ext_ovf_d = 1'b1;
        end
        CL_JUMP: jump_err_d = 1'b1;
        default: ;
      endcase
    end else begin
      state_d = ST_TRACK;
      valid_d = 1'b1;
    end
    // Edge-detect on the count itself so a cmp_val change alone never fires.
    hit_d = valid_d && ({ext_d, q_r_d} == cmp_val) && ({ext_d, q_r_d} != full_count);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      q_r      <= '0;
      ext      <= '0;
      valid    <= 1'b0;
      wrap_up  <= 1'b0;
      wrap_dn  <= 1'b0;
      hit      <= 1'b0;
      ext_ovf  <= 1'b0;
      jump_err <= 1'b0;
    end else begin
      state    <= state_d;
      q_r      <= q_r_d;
      ext      <= ext_d;
      valid    <= valid_d;
      wrap_up  <= wrap_up_d;
      wrap_dn  <= wrap_dn_d;
      hit      <= hit_d;
      ext_ovf  <= ext_ovf_d;
      jump_err <= jump_err_d;
    end
  end
endmodule

// File: doc/count_wrap_extender.md
# count_wrap_extender

Downstream companion to the 4-bit loadable up/down counter. Samples the counter's `q` every clock, detects wrap-around (15→0 up, 0→15 down) and extends the 4-bit count into a wider signed running count. Load events discontinue the count and trigger a resync. Outputs wrap pulses, a compare hit, and sticky overflow and illegal-jump flags for status logic.

## Interface
- `CNT_W`, 4: width of counter value being tracked.
- `EXT_W`, 8: width of extension (wrap) counter, two's complement.

- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `q_in`  in  CNT_W  counter's registered output.
- `load_in`  in  1  same signal that drives the counter's `load`.
- `cmp_val`  in  EXT_W+CNT_W  compare value for `hit`.
- `full_count`  out  EXT_W+CNT_W  `{ext, q_r}`, registered.
- `valid`  out  1  `full_count` is trustworthy.
- `wrap_up`  out  1  one-cycle pulse, up wrap detected.
- `wrap_dn`  out  1  one-cycle pulse, down wrap detected.
- `hit`  out  1  one-cycle pulse, `full_count` changed to `cmp_val`.
- `ext_ovf`  out  1  sticky, extension counter wrapped signed.
- `jump_err`  out  1  sticky, non-adjacent change without load.

## Operation
- Internal registers:
  - `q_r`: last sample of `q_in`.
  - `ext`: EXT_W signed.
  - State: INIT, TRACK, RESYNC.
- Step classification of (`q_r`, `q_in`):
  - HOLD: equal.
  - STEP: differ by ±1, no wrap.
  - WRAP_UP: `q_r`=2^CNT_W−1 and `q_in`=0.
  - WRAP_DN: `q_r`=0 and `q_in`=2^CNT_W−1.
  - JUMP: anything else.
- Priority at each edge: `rst` > `load_in` > state behaviour.
- `rst`:
  - State goes to INIT.
  - `q_r`, `ext`, and all outputs go to 0.
- `load_in`=1, any state:
  - `ext`←0, `q_r`←`q_in`, state goes to RESYNC.
  - Pulses low; the classification at this edge is discarded.
  - Holding `load_in` keeps the block in RESYNC.
- INIT, no load:
  - `q_r`←`q_in`, `ext` stays 0, state goes to TRACK, `valid`←1.
- RESYNC, no load:
  - `q_r`←`q_in` (the loaded value); no classification.
  - State goes to TRACK, `valid`←1.
- TRACK, no load:
  - `q_r`←`q_in` on every class.
  - WRAP_UP: `ext`+1, `wrap_up`←1.
  - WRAP_DN: `ext`−1, `wrap_dn`←1.
  - JUMP: `ext` unchanged, `jump_err`←1.
- `ext` wraps modulo 2^EXT_W.
  - +1 from max positive, or −1 from min negative, sets `ext_ovf`.
- `hit`: asserted when the new `full_count` equals `cmp_val` and differs from the previous `full_count`, with `valid` being 1 after the edge.
  - Re-asserts only after leaving and returning to `cmp_val`.
  - A `cmp_val` change alone never fires `hit`.
- Sticky flags are cleared by `rst` only.
- `valid` is 0 in INIT and for the single RESYNC cycle.

## Timing
- All outputs are registered.
- Latency: one clock from a `q_in` change to the matching `full_count`, pulse, or flag.
- Pulses last exactly one cycle. Back-to-back wraps (e.g. 15,0,15,0) give alternating pulses on consecutive cycles.
- Load sequence, with load edge E:
  - `valid`=0 in the cycle after E.
  - `full_count`={0, loaded value} and `valid`=1 after E+1.
- The counter changing at the same edge the block sees `load_in` produces no pulse or error.
- `rst` asserted mid-sequence: state clears at that edge. Recovery takes one INIT cycle after `rst` drops.

## Structure
- Shared package `count_wrap_pkg`:
  - State enum (ST_INIT, ST_TRACK, ST_RESYNC).
  - Step-class enum (CL_HOLD, CL_STEP, CL_WRAP_UP, CL_WRAP_DN, CL_JUMP).
  - Default `CNT_W`/`EXT_W` constants.
- One combinational sub-module, `count_step_classify`: (`q_r`, `q_in`) → step class.
- FSM, extension counter, compare, and flags stay in the top module.

## Test plan
- Reset: `rst`=1 for 2 cycles with `q_in`=7 → all outputs 0. After release: 1 cycle INIT, then `valid`=1, `full_count`=0x007.
- Up wrap: `q_in` 14,15,0,1 → `full_count` 0x00E,0x00F,0x010,0x011. Single `wrap_up` pulse coinciding with 0x010.
- Down wrap from reset baseline 0: `q_in` 0→15 → `full_count`=0xFFF, one `wrap_dn` pulse, `ext_ovf`=0.
- Load: with `ext`=3, `load_in`=1 for one cycle and `q_in` then 5:
  - `valid` low for one cycle, then `full_count`=0x005.
  - No pulses; `jump_err` stays 0.
- Jump: `q_in` 3→9 without load → `jump_err`=1 and stays 1; `full_count` low nibble 9, `ext` unchanged.
- Overflow and hit:
  - Drive `ext` to 0x7F via up wraps, wrap once more → `full_count`=0x800, `ext_ovf`=1.
  - `cmp_val`=0x805 → `hit` pulses once when `q_in` reaches 5; no re-assert while holding 5.
